ingress_fifo: RTL and testbench

- Synchronous valid/ready stream buffer at the ingress of `top`.
- Absorbs bursts from the upstream source and decouples its backpressure from the core logic.
- Provides occupancy and almost-full status for flow control and debug.
- Operation is first-word-fall-through (FWFT), so `top` sees head data without a read request.

---
 rtl/ingress_fifo_pkg.sv | 10 +
 rtl/ingress_fifo_if.sv | 23 ++
 rtl/ingress_fifo_mem.sv | 22 ++
 rtl/ingress_fifo.sv | 103 ++++++++++
 tb/tb_ingress_fifo.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/ingress_fifo_pkg.sv
// rtl/ingress_fifo_pkg.sv - shared widths and types for the ingress buffer
package ingress_fifo_pkg;
  localparam int INGRESS_DATA_W       = 8;
  localparam int INGRESS_DEPTH        = 16;
  localparam int INGRESS_AFULL_THRESH = 12;
  localparam int INGRESS_CNT_W        = $clog2(INGRESS_DEPTH) + 1;

  typedef logic [INGRESS_DATA_W-1:0] ingress_data_t;
  typedef logic [INGRESS_CNT_W-1:0]  ingress_cnt_t;
endpackage

// File: rtl/ingress_fifo_if.sv
// rtl/ingress_fifo_if.sv - upstream and downstream valid/ready stream pair
interface ingress_fifo_if
  import ingress_fifo_pkg::*;
#(
  parameter int DATA_W = INGRESS_DATA_W
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/ingress_fifo_mem.sv
// rtl/ingress_fifo_mem.sv - register array, synchronous write, asynchronous read
module fifo_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [DATA_W-1:0]        i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [DATA_W-1:0]        o_rdata
);
  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/ingress_fifo.sv
// rtl/ingress_fifo.sv - FWFT ingress buffer with registered handshakes and status
module ingress_fifo
  import ingress_fifo_pkg::*;
#(
  parameter int DATA_W       = INGRESS_DATA_W,
  parameter int DEPTH        = INGRESS_DEPTH,
  parameter int AFULL_THRESH = INGRESS_AFULL_THRESH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  ingress_fifo_if.slave          s_if,
  output logic [$clog2(DEPTH):0] count,
  output logic                   almost_full,
  output logic                   overflow_seen
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic [CW-1:0]     w_count_nxt;
  logic              r_in_ready;
  logic              r_out_valid;
  logic              r_afull;
  logic              r_ovf;
  logic [4:0]        r_ovf_cnt;
  logic [4:0]        w_ovf_cnt_nxt;
  logic              w_push;
  logic              w_pop;
  logic [DATA_W-1:0] w_rdata;

  // flush wins over any handshake in the same cycle
  assign w_push = s_if.in_valid && r_in_ready && !flush;
  assign w_pop  = r_out_valid && s_if.out_ready && !flush;

  always_comb begin
    w_count_nxt = r_count;
    if (flush) begin
      w_count_nxt = '0;
    end else if (w_push && !w_pop) begin
      w_count_nxt = r_count + CW'(1);
    end else if (w_pop && !w_push) begin
      w_count_nxt = r_count - CW'(1);
    end
  end

  always_comb begin
    w_ovf_cnt_nxt = '0;
    if (s_if.in_valid && !r_in_ready) begin
      w_ovf_cnt_nxt = (r_ovf_cnt == 5'd31) ? r_ovf_cnt : r_ovf_cnt + 5'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_afull     <= 1'b0;
      r_ovf_cnt   <= '0;
      r_ovf       <= 1'b0;
    end else begin
      r_count     <= w_count_nxt;
      r_in_ready  <= (w_count_nxt != CW'(DEPTH));
      r_out_valid <= (w_count_nxt != '0);
      r_afull     <= (w_count_nxt >= CW'(AFULL_THRESH));
      if (flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_ovf_cnt <= w_ovf_cnt_nxt;
      if (w_ovf_cnt_nxt >= 5'd16) r_ovf <= 1'b1;
    end
  end

  // Asynchronous read of mem[rd_ptr] already reflects a word written into an
  // empty FIFO at the previous edge, so no separate bypass register is needed.
  fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_push),
    .i_waddr (r_wr_ptr),
    .i_wdata (s_if.in_data),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rdata)
  );

  assign s_if.in_ready  = r_in_ready;
  assign s_if.out_valid = r_out_valid;
  assign s_if.out_data  = w_rdata;
  assign count          = r_count;
  assign almost_full    = r_afull;
  assign overflow_seen  = r_ovf;
endmodule

// File: tb/tb_ingress_fifo.sv
// tb/tb_ingress_fifo.sv - scoreboard bench for ingress_fifo against a queue model
module tb_ingress_fifo;
  import ingress_fifo_pkg::*;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AF    = 12;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         flush = 1'b0;
  ingress_cnt_t count;
  logic         almost_full;
  logic         overflow_seen;

  int total = 0;
  int bad   = 0;

  ingress_fifo_if #(.DATA_W(DW)) tb_if ();

  ingress_fifo #(
    .DATA_W       (DW),
    .DEPTH        (DEPTH),
    .AFULL_THRESH (AF)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .s_if          (tb_if),
    .count         (count),
    .almost_full   (almost_full),
    .overflow_seen (overflow_seen)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  // reference model: plain queue plus a few flags
  ingress_data_t sb[$];
  bit            started = 0;
  bit            exp_ovf = 0;
  int            run = 0;
  bit            p_iv = 0, p_ir = 0, p_ov = 0, p_or = 0, p_fl = 0, p_pop = 0;
  ingress_data_t p_id = '0, p_od = '0;

  always @(negedge clk) begin
    int  size;
    bit  exp_ready;
    bit  push;
    bit  pop;
    if (rst) begin
      chk("rst_in_ready", int'(tb_if.in_ready), 0);
      chk("rst_out_valid", int'(tb_if.out_valid), 0);
      chk("rst_count", int'(count), 0);
      chk("rst_almost_full", int'(almost_full), 0);
      chk("rst_overflow_seen", int'(overflow_seen), 0);
      sb.delete();
      started = 0;
      exp_ovf = 0;
      run     = 0;
      p_ov    = 0;
      p_iv    = 0;
    end else begin
      size      = sb.size();
      exp_ready = started && (size != DEPTH);
      chk("in_ready", int'(tb_if.in_ready), int'(exp_ready));
      chk("out_valid", int'(tb_if.out_valid), int'(size != 0));
      chk("count", int'(count), size);
      chk("almost_full", int'(almost_full), int'(size >= AF));
      chk("overflow_seen", int'(overflow_seen), int'(exp_ovf));
      if (size != 0) chk("out_data", int'(tb_if.out_data), int'(sb[0]));
      if (p_ov && !p_pop && !p_fl) chk("out_valid_hold", int'(tb_if.out_valid), 1);
      if (p_ov && !p_or && !p_fl && tb_if.out_valid)
        chk("out_data_stable", int'(tb_if.out_data), int'(p_od));
      if (p_iv && !p_ir && !p_fl && tb_if.in_valid)
        chk("in_data_stable", int'(tb_if.in_data), int'(p_id));

      push = tb_if.in_valid && exp_ready && !flush;
      pop  = (size != 0) && tb_if.out_ready && !flush;
      if (tb_if.in_valid && !exp_ready) begin
        if (run < 31) run++;
      end else begin
        run = 0;
      end
      if (run >= 16) exp_ovf = 1;

      // egress side pops the expected word, ingress side records accepted words
      if (flush) begin
        sb.delete();
      end else begin
        if (pop)  void'(sb.pop_front());
        if (push) sb.push_back(tb_if.in_data);
      end

      started = 1;
      p_iv  = tb_if.in_valid;
      p_ir  = tb_if.in_ready;
      p_id  = tb_if.in_data;
      p_ov  = tb_if.out_valid;
      p_or  = tb_if.out_ready;
      p_od  = tb_if.out_data;
      p_fl  = flush;
      p_pop = tb_if.out_valid && tb_if.out_ready;
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic drv(input bit v, input logic [7:0] d, input bit r, input bit f);
    tb_if.in_valid  = v;
    tb_if.in_data   = d;
    tb_if.out_ready = r;
    flush           = f;
  endtask

  task automatic push_n(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      drv(1'b1, 8'(base + i), 1'b0, 1'b0);
      cyc(1);
    end
  endtask

  initial begin
    drv(1'b0, 8'h00, 1'b0, 1'b0);
    rst = 1'b1;
    cyc(3);
    rst = 1'b0;
    cyc(2);

    // single word
    drv(1'b1, 8'hA5, 1'b0, 1'b0);
    cyc(1);
    drv(1'b0, 8'h00, 1'b0, 1'b0);
    cyc(2);
    drv(1'b0, 8'h00, 1'b1, 1'b0);
    cyc(1);
    drv(1'b0, 8'h00, 1'b0, 1'b0);
    cyc(2);

    // fill, hold 0xFF against full, pop once, then drain through the wrap
    push_n(16, 0);
    drv(1'b1, 8'hFF, 1'b0, 1'b0);
    cyc(3);
    drv(1'b1, 8'hFF, 1'b1, 1'b0);
    cyc(1);
    drv(1'b1, 8'hFF, 1'b0, 1'b0);
    cyc(1);
    drv(1'b0, 8'h00, 1'b1, 1'b0);
    cyc(18);

    // streaming with a non-empty FIFO
    push_n(4, 8'h40);
    for (int i = 0; i < 64; i++) begin
      drv(1'b1, 8'(8'h44 + i), 1'b1, 1'b0);
      cyc(1);
    end
    drv(1'b0, 8'h00, 1'b1, 1'b0);
    cyc(8);

    // flush with a concurrent push
    push_n(5, 8'h90);
    drv(1'b1, 8'h77, 1'b0, 1'b1);
    cyc(1);
    drv(1'b0, 8'h00, 1'b0, 1'b0);
    cyc(2);

    // overflow: hold in_valid against a full FIFO, then flush
    push_n(16, 8'hC0);
    drv(1'b1, 8'hEE, 1'b0, 1'b0);
    cyc(20);
    chk("overflow_set", int'(overflow_seen), 1);
    drv(1'b0, 8'h00, 1'b0, 1'b1);
    cyc(1);
    drv(1'b0, 8'h00, 1'b0, 1'b0);
    cyc(3);
    chk("overflow_after_flush", int'(overflow_seen), 1);

    // randomized traffic, upstream obeys the hold rule
    for (int i = 0; i < 400; i++) begin
      bit hold;
      @(negedge clk);
      hold = tb_if.in_valid && !tb_if.in_ready && !flush;
      @(posedge clk);
      #2;
      if (!hold) begin
        tb_if.in_valid = ($urandom_range(0, 99) < 60);
        tb_if.in_data  = 8'($urandom);
      end
      tb_if.out_ready = ($urandom_range(0, 99) < 55);
      flush           = ($urandom_range(0, 63) == 0);
    end
    drv(1'b0, 8'h00, 1'b1, 1'b0);
    cyc(20);

    // reset mid-operation clears immediately
    push_n(6, 8'h30);
    drv(1'b0, 8'h00, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    chk("async_rst_out_valid", int'(tb_if.out_valid), 0);
    chk("async_rst_count", int'(count), 0);
    chk("async_rst_in_ready", int'(tb_if.in_ready), 0);
    chk("async_rst_overflow", int'(overflow_seen), 0);
    cyc(2);
    rst = 1'b0;
    drv(1'b0, 8'h00, 1'b1, 1'b0);
    cyc(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad + 1);
    $fatal(1, "watchdog");
  end
endmodule
